acq_burst_scheduler: RTL and testbench
======================================

// Module: acq_burst_scheduler
// PURPOSE
//  Controls the sensor acquisition datapath. Runs a programmed number of bursts;
//  a burst is one TLAST-terminated AXIS packet train. Drives the datapath enable,
//  raw-mode select and packet count. Monitors the datapath's AXIS output for
//  burst completion and stalls. Status and interrupt go to the PS register block.
// PARAMETERS
//  CNT_W    16  width of the burst count, packet count and burst counter
//  TMO_W    24  width of the stall watchdog
//  IVL_W    32  width of the burst-interval timer
// PORTS
//  master_clock           in   1      40 MHz system clock
//  resetn                 in   1      async active-low reset
//  cfg_start              in   1      1-cycle pulse; starts a run (ignored unless IDLE or ERROR)
//  cfg_abort              in   1      1-cycle pulse; stops a run from any state
//  cfg_raw_mode           in   1      1=raw pixel packets, 0=processed (centroid) packets
//  cfg_num_bursts         in   CNT_W  bursts per run; 0 = continuous until abort
//  cfg_pkts_per_burst     in   CNT_W  packets per burst; 0 treated as 1
//  cfg_interval           in   IVL_W  clocks from burst start to next burst start; 0 = back-to-back
//  cfg_timeout            in   TMO_W  stall limit in clocks without an accepted beat; 0 = off
//  mon_tvalid             in   1      snoop of datapath data_tvalid
//  mon_tready             in   1      snoop of datapath data_tready
//  mon_tlast              in   1      snoop of datapath data_tlast
//  acq_enable             out  1      drives datapath resetn (1 = acquire)
//  acq_send_raw_data      out  1      drives datapath send_raw_data
//  acq_number_of_packet   out  CNT_W  drives datapath number_of_packet
//  sts_busy               out  1      1 in ARM/RUN/GAP
//  sts_done               out  1      1-cycle pulse when a run completes
//  sts_timeout            out  1      sticky; watchdog fired
//  sts_overrun            out  1      sticky; a burst took longer than cfg_interval
//  sts_burst_count        out  CNT_W  bursts completed in the current run
//  irq                    out  1      1-cycle pulse on done or on timeout
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. All counters 0.
//  Beat: mon_tvalid & mon_tready. End of burst: beat & mon_tlast.
//  Config latch: at cfg_start, latch raw_mode, num_bursts, pkts, interval and timeout.
//   Config changes during a run have no effect.
//  acq_number_of_packet = max(pkts,1)-1. The datapath emits N+1 packets for
//   number_of_packet=N, and the last one carries TLAST. Output is registered
//   and stable whenever acq_enable=1.
//  States:
//   IDLE:  acq_enable=0. On cfg_start: latch config; clear burst_count,
//          sts_timeout and sts_overrun; go to ARM.
//   ARM:   one cycle with acq_enable=0 so the mode and packet count settle;
//          then go to RUN.
//   RUN:   acq_enable=1. Timer ivl counts from 0 at RUN entry and saturates
//          at all-ones. Watchdog wd counts each cycle and clears on any beat.
//          - On end of burst: burst_count++. If cfg_interval!=0 and
//            ivl>=cfg_interval, set sts_overrun.
//            If num_bursts!=0 and burst_count+1==num_bursts: go to DONE.
//            Otherwise go to GAP.
//          - If timeout!=0 and wd==timeout-1 with no beat this cycle: go to
//            ERROR and set sts_timeout.
//          - End of burst takes priority over timeout in the same cycle.
//   GAP:   acq_enable=0. ivl keeps counting. Stay at least 2 cycles so the
//          datapath time stamp and state are reset. Go to RUN once
//          ivl>=cfg_interval-1 and the 2-cycle minimum is met.
//   DONE:  one cycle. sts_done=1, irq=1, acq_enable=0. Go to IDLE.
//   ERROR: acq_enable=0. Pulse irq on entry. Wait for cfg_start (same as from
//          IDLE) or cfg_abort (go to IDLE).
//  Abort: takes priority in every state. Next state is IDLE and acq_enable=0
//   on the next edge. No sts_done or irq. burst_count holds its value.
//  cfg_start in ARM/RUN/GAP/DONE is ignored. Start and abort in the same cycle:
//   abort wins.
//  burst_count wraps modulo 2^CNT_W in continuous mode.
//  acq_enable rising edge is registered and glitch-free.
//  Async reset mid-run behaves exactly like power-on reset.
// TESTING
//  T1 num_bursts=3, pkts=2, interval=0, timeout=0; TB sends TLAST per burst
//     -> 3 acq_enable high windows, each gap >=2 cycles; burst_count=3;
//        sts_done and irq pulse once; acq_number_of_packet=1.
//  T2 num_bursts=2, interval=1000, burst lasts 300 clocks
//     -> 2nd acq_enable rise exactly 1000 clocks after the 1st; sts_overrun=0.
//     Repeat with the burst lasting 1200 clocks -> sts_overrun=1; min gap is 2.
//  T3 timeout=50; tvalid held 0 in RUN
//     -> ERROR after 50 cycles; sts_timeout=1; irq pulse; acq_enable=0.
//     Then cfg_start -> sts_timeout clears and the run restarts.
//  T4 num_bursts=0, pkts=0; 5 bursts, then cfg_abort mid-burst
//     -> acq_number_of_packet=0; acq_enable=0 next edge; state IDLE; no sts_done.
//  T5 cfg_start during RUN with changed cfg_raw_mode -> acq_send_raw_data
//     unchanged. Start+abort in the same cycle from IDLE -> stays IDLE.
//  T6 resetn low mid-GAP -> all outputs 0 asynchronously; after release,
//     idle until cfg_start.

Source files
------------

// File: rtl/acq_burst_scheduler_if.sv
// ----------------------------------------------------------------------------
// acq_burst_scheduler_if
// Bundles the signals between the acquisition burst scheduler, the PS
// register block and the snooped datapath AXIS output.
//   cfg_*  : run configuration and start/abort pulses (from PS)
//   mon_*  : passive snoop of the datapath AXIS handshake
//   acq_*  : datapath control (enable, raw select, packet count)
//   sts_*  : run status back to PS, irq : done/timeout interrupt pulse
// Modports: master = PS/datapath side, slave = the scheduler.
// ----------------------------------------------------------------------------
interface acq_burst_scheduler_if #(
    parameter int CNT_W = 16,
    parameter int TMO_W = 24,
    parameter int IVL_W = 32
) ();
    logic             cfg_start;
    logic             cfg_abort;
    logic             cfg_raw_mode;
    logic [CNT_W-1:0] cfg_num_bursts;
    logic [CNT_W-1:0] cfg_pkts_per_burst;
    logic [IVL_W-1:0] cfg_interval;
    logic [TMO_W-1:0] cfg_timeout;
    logic             mon_tvalid;
    logic             mon_tready;
    logic             mon_tlast;
    logic             acq_enable;
    logic             acq_send_raw_data;
    logic [CNT_W-1:0] acq_number_of_packet;
    logic             sts_busy;
    logic             sts_done;
    logic             sts_timeout;
    logic             sts_overrun;
    logic [CNT_W-1:0] sts_burst_count;
    logic             irq;

    modport master (
        output cfg_start, cfg_abort, cfg_raw_mode, cfg_num_bursts,
               cfg_pkts_per_burst, cfg_interval, cfg_timeout,
               mon_tvalid, mon_tready, mon_tlast,
        input  acq_enable, acq_send_raw_data, acq_number_of_packet,
               sts_busy, sts_done, sts_timeout, sts_overrun,
               sts_burst_count, irq
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_raw_mode, cfg_num_bursts,
               cfg_pkts_per_burst, cfg_interval, cfg_timeout,
               mon_tvalid, mon_tready, mon_tlast,
        output acq_enable, acq_send_raw_data, acq_number_of_packet,
               sts_busy, sts_done, sts_timeout, sts_overrun,
               sts_burst_count, irq
    );
endinterface

// File: rtl/acq_burst_scheduler.sv
// ----------------------------------------------------------------------------
// acq_burst_scheduler
// Runs a programmed number of acquisition bursts (one TLAST-terminated AXIS
// packet train each), gating the datapath through acq_enable and watching
// its AXIS output for burst completion and stalls.
// Ports:
//   master_clock : system clock
//   resetn       : asynchronous active-low reset
//   io           : acq_burst_scheduler_if.slave (config, snoop, control,
//                  status, irq)
// All outputs are registered.
// ----------------------------------------------------------------------------
module acq_burst_scheduler #(
    parameter int CNT_W = 16,
    parameter int TMO_W = 24,
    parameter int IVL_W = 32
) (
    input  logic                  master_clock,
    input  logic                  resetn,
    acq_burst_scheduler_if.slave  io
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_RUN, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t state_q, state_d;

    logic             raw_q, raw_d;
    logic [CNT_W-1:0] nb_q, nb_d;
    logic [CNT_W-1:0] npkt_q, npkt_d;
    logic [IVL_W-1:0] ivl_cfg_q, ivl_cfg_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [IVL_W-1:0] ivl_q, ivl_d;
    logic [TMO_W-1:0] wd_q, wd_d;
    logic             gap_seen_q, gap_seen_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             irq_q, irq_d;

    logic beat, eob, start_ok, wd_fire, last_burst, gap_ready, overrun_hit;

    assign beat        = io.mon_tvalid & io.mon_tready;
    assign eob         = beat & io.mon_tlast;
    // Abort beats start when both arrive together.
    assign start_ok    = io.cfg_start & ~io.cfg_abort &
                         ((state_q == S_IDLE) || (state_q == S_ERROR));
    assign wd_fire     = (tmo_q != '0) && (wd_q == tmo_q - TMO_W'(1)) && !beat;
    assign last_burst  = (nb_q != '0) && (burst_cnt_q + CNT_W'(1) == nb_q);
    // ivl+1 >= interval, done one bit wider so interval=0 needs no special case.
    assign gap_ready   = gap_seen_q &&
                         (({1'b0, ivl_q} + {{IVL_W{1'b0}}, 1'b1}) >= {1'b0, ivl_cfg_q});
    assign overrun_hit = (ivl_cfg_q != '0) && (ivl_q >= ivl_cfg_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_ARM;
            S_ARM:   state_d = S_RUN;
            S_RUN: begin
                if (eob)          state_d = last_burst ? S_DONE : S_GAP;
                else if (wd_fire) state_d = S_ERROR;
            end
            S_GAP:   if (gap_ready) state_d = S_RUN;
            S_DONE:  state_d = S_IDLE;
            S_ERROR: if (start_ok) state_d = S_ARM;
            default: state_d = S_IDLE;
        endcase
        if (io.cfg_abort) state_d = S_IDLE;
    end

    always_comb begin
        raw_d       = raw_q;
        nb_d        = nb_q;
        npkt_d      = npkt_q;
        ivl_cfg_d   = ivl_cfg_q;
        tmo_d       = tmo_q;
        burst_cnt_d = burst_cnt_q;
        ivl_d       = ivl_q;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;

        if (start_ok) begin
            raw_d       = io.cfg_raw_mode;
            nb_d        = io.cfg_num_bursts;
            npkt_d      = (io.cfg_pkts_per_burst == '0) ? '0
                                                        : io.cfg_pkts_per_burst - CNT_W'(1);
            ivl_cfg_d   = io.cfg_interval;
            tmo_d       = io.cfg_timeout;
            burst_cnt_d = '0;
            timeout_d   = 1'b0;
            overrun_d   = 1'b0;
        end

        if (state_q == S_RUN && eob && !io.cfg_abort) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            if (overrun_hit) overrun_d = 1'b1;
        end
        if (state_q == S_RUN && state_d == S_ERROR) timeout_d = 1'b1;

        // Interval timer measures burst start to next burst start.
        if (state_d == S_RUN && state_q != S_RUN)
            ivl_d = '0;
        else if ((state_q == S_RUN || state_q == S_GAP) && ivl_q != '1)
            ivl_d = ivl_q + IVL_W'(1);

        wd_d       = (state_q == S_RUN && !beat) ? wd_q + TMO_W'(1) : '0;
        // Set from the second GAP cycle onward: enforces the 2-cycle minimum gap.
        gap_seen_d = (state_q == S_GAP);

        en_d   = (state_d == S_RUN);
        busy_d = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
        irq_d  = done_d || (state_d == S_ERROR && state_q != S_ERROR);
    end

    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            raw_q       <= 1'b0;
            nb_q        <= '0;
            npkt_q      <= '0;
            ivl_cfg_q   <= '0;
            tmo_q       <= '0;
            burst_cnt_q <= '0;
            ivl_q       <= '0;
            wd_q        <= '0;
            gap_seen_q  <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            raw_q       <= raw_d;
            nb_q        <= nb_d;
            npkt_q      <= npkt_d;
            ivl_cfg_q   <= ivl_cfg_d;
            tmo_q       <= tmo_d;
            burst_cnt_q <= burst_cnt_d;
            ivl_q       <= ivl_d;
            wd_q        <= wd_d;
            gap_seen_q  <= gap_seen_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            irq_q       <= irq_d;
        end
    end

    assign io.acq_enable           = en_q;
    assign io.acq_send_raw_data    = raw_q;
    assign io.acq_number_of_packet = npkt_q;
    assign io.sts_busy             = busy_q;
    assign io.sts_done             = done_q;
    assign io.sts_timeout          = timeout_q;
    assign io.sts_overrun          = overrun_q;
    assign io.sts_burst_count      = burst_cnt_q;
    assign io.irq                  = irq_q;

endmodule

// File: tb/tb_acq_burst_scheduler.sv
// ----------------------------------------------------------------------------
// tb_acq_burst_scheduler
// Directed bench for acq_burst_scheduler: normal runs, interval timing and
// overrun, stall watchdog, continuous mode with abort, config freeze and
// asynchronous reset.
// ----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_acq_burst_scheduler;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;

    acq_burst_scheduler_if #(.CNT_W(16), .TMO_W(24), .IVL_W(32)) io ();

    acq_burst_scheduler #(.CNT_W(16), .TMO_W(24), .IVL_W(32)) dut (
        .master_clock (clk),
        .resetn       (rst_n),
        .io           (io.slave)
    );

    initial clk = 1'b0;
    always #12.5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {enable, raw, busy, done, timeout, overrun, irq}
    function automatic logic [6:0] flags();
        return {io.acq_enable, io.acq_send_raw_data, io.sts_busy, io.sts_done,
                io.sts_timeout, io.sts_overrun, io.irq};
    endfunction

    task automatic set_cfg(input logic raw, input int nb, input int pk,
                           input int ivl, input int tmo);
        io.cfg_raw_mode       = raw;
        io.cfg_num_bursts     = 16'(nb);
        io.cfg_pkts_per_burst = 16'(pk);
        io.cfg_interval       = 32'(ivl);
        io.cfg_timeout        = 24'(tmo);
    endtask

    // Pulse start, expect ARM then the first RUN cycle.
    task automatic start_run(input string tag);
        io.cfg_start = 1'b1;
        tick();
        io.cfg_start = 1'b0;
        chk({tag, "_arm"}, {io.sts_busy, io.acq_enable}, 2'b10);
        tick();
        chk({tag, "_run"}, io.acq_enable, 1'b1);
    endtask

    // Count samples until acq_enable reaches level, bounded by budget.
    task automatic wait_en(input string tag, input logic level, input int budget,
                           output int n);
        n = 0;
        while (io.acq_enable !== level && n < budget) begin
            n++;
            tick();
        end
        chk({tag, "_reached"}, io.acq_enable, level);
    endtask

    task automatic run_burst(input int pre_idle, input int nbeats);
        io.mon_tvalid = 1'b0;
        io.mon_tlast  = 1'b0;
        repeat (pre_idle) tick();
        for (int i = 0; i < nbeats; i++) begin
            io.mon_tvalid = 1'b1;
            io.mon_tready = 1'b1;
            io.mon_tlast  = (i == nbeats - 1);
            tick();
        end
        io.mon_tvalid = 1'b0;
        io.mon_tlast  = 1'b0;
    endtask

    initial begin
        int n, c1;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        io.cfg_start = 1'b0;
        io.cfg_abort = 1'b0;
        io.mon_tvalid = 1'b0;
        io.mon_tready = 1'b1;
        io.mon_tlast  = 1'b0;
        set_cfg(1'b0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_flags", flags(), 7'b0);
        chk("rst_count", io.sts_burst_count, 16'd0);
        chk("rst_npkt", io.acq_number_of_packet, 16'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_flags", flags(), 7'b0);

        // T1: three bursts, back-to-back
        set_cfg(1'b1, 3, 2, 0, 0);
        start_run("t1");
        chk("t1_npkt", io.acq_number_of_packet, 16'd1);
        chk("t1_raw", io.acq_send_raw_data, 1'b1);
        for (int b = 0; b < 3; b++) begin
            wait_en("t1_win", 1'b1, 20, n);
            run_burst(0, 4);
            chk("t1_count", io.sts_burst_count, 64'(b + 1));
            if (b < 2) begin
                chk("t1_gapflags", {io.acq_enable, io.sts_busy, io.sts_done}, 3'b010);
                wait_en("t1_gap", 1'b1, 20, n);
                chk("t1_gaplen", n, 2);
            end else begin
                chk("t1_done", {io.acq_enable, io.sts_busy, io.sts_done, io.irq}, 4'b0011);
                tick();
                chk("t1_after", {io.sts_done, io.irq, io.sts_busy}, 3'b000);
            end
        end

        // T2a: interval 1000, 300-clock burst
        set_cfg(1'b0, 2, 1, 1000, 0);
        start_run("t2a");
        c1 = cyc;
        run_burst(299, 1);
        wait_en("t2a_rise", 1'b1, 2000, n);
        chk("t2a_period", cyc - c1, 1000);
        chk("t2a_ovr", io.sts_overrun, 1'b0);
        run_burst(0, 1);
        chk("t2a_done", {io.sts_done, io.sts_overrun, io.sts_burst_count}, {2'b10, 16'd2});

        // T2b: 1200-clock burst overruns the interval, gap falls to minimum
        tick();
        start_run("t2b");
        run_burst(1199, 1);
        chk("t2b_ovr", io.sts_overrun, 1'b1);
        wait_en("t2b_rise", 1'b1, 2000, n);
        chk("t2b_gap", n, 2);
        run_burst(0, 1);
        chk("t2b_done", {io.sts_done, io.sts_overrun}, 2'b11);

        // T3: stall watchdog
        tick();
        set_cfg(1'b0, 1, 1, 0, 50);
        start_run("t3");
        wait_en("t3_stall", 1'b0, 200, n);
        chk("t3_hicycles", n, 50);
        chk("t3_err", {io.acq_enable, io.sts_busy, io.sts_timeout, io.irq, io.sts_done}, 5'b00110);
        tick();
        chk("t3_irqpulse", {io.irq, io.sts_timeout}, 2'b01);
        start_run("t3r");
        chk("t3_tmoclr", io.sts_timeout, 1'b0);
        run_burst(0, 1);
        chk("t3_done", io.sts_done, 1'b1);

        // T4: continuous mode, abort mid-burst
        tick();
        set_cfg(1'b0, 0, 0, 0, 0);
        start_run("t4");
        chk("t4_npkt", io.acq_number_of_packet, 16'd0);
        for (int b = 0; b < 5; b++) begin
            wait_en("t4_win", 1'b1, 20, n);
            run_burst(0, 2);
        end
        wait_en("t4_win6", 1'b1, 20, n);
        chk("t4_count", io.sts_burst_count, 16'd5);
        io.mon_tvalid = 1'b1;
        io.cfg_abort  = 1'b1;
        tick();
        io.mon_tvalid = 1'b0;
        io.cfg_abort  = 1'b0;
        chk("t4_abort", {io.acq_enable, io.sts_busy, io.sts_done, io.irq}, 4'b0000);
        chk("t4_hold", io.sts_burst_count, 16'd5);
        tick();
        chk("t4_idle", {io.acq_enable, io.sts_busy, io.sts_done}, 3'b000);

        // T5: config frozen during run; start+abort from idle
        set_cfg(1'b0, 1, 3, 0, 0);
        start_run("t5");
        set_cfg(1'b1, 1, 7, 0, 0);
        io.cfg_start = 1'b1;
        tick();
        io.cfg_start = 1'b0;
        chk("t5_raw", io.acq_send_raw_data, 1'b0);
        chk("t5_npkt", io.acq_number_of_packet, 16'd2);
        chk("t5_en", io.acq_enable, 1'b1);
        run_burst(0, 1);
        chk("t5_done", io.sts_done, 1'b1);
        tick();
        io.cfg_start = 1'b1;
        io.cfg_abort = 1'b1;
        tick();
        io.cfg_start = 1'b0;
        io.cfg_abort = 1'b0;
        chk("t5_sa", {io.sts_busy, io.acq_enable}, 2'b00);
        tick();
        chk("t5_sa2", {io.sts_busy, io.acq_enable}, 2'b00);

        // T6: async reset during GAP
        set_cfg(1'b1, 2, 5, 100, 0);
        start_run("t6");
        run_burst(0, 1);
        chk("t6_gap", {io.acq_enable, io.sts_busy, io.acq_send_raw_data}, 3'b011);
        #3;
        rst_n = 1'b0;
        #2;
        chk("t6_rflags", flags(), 7'b0);
        chk("t6_rcount", io.sts_burst_count, 16'd0);
        chk("t6_rnpkt", io.acq_number_of_packet, 16'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t6_idle", flags(), 7'b0);
        start_run("t6r");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop if the directed sequence wedges somewhere unexpected.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
